// File: rtl/decode_issue_pkg.sv
// Shared widths and the fetch-to-decode entry record used by the decode
// sequencing front end.
package decode_issue_pkg;

    localparam int ADDR_WIDTH   = 64;
    localparam int INST_WIDTH   = 32;
    localparam int PID_WIDTH    = 20;
    localparam int TID_WIDTH    = 16;
    localparam int MAJ_ID_WIDTH = 64;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  is64;
        logic [PID_WIDTH-1:0]  pid;
        logic [TID_WIDTH-1:0]  tid;
    } fetch_entry_t;

endpackage

// File: rtl/decode_issue_fifo.sv
// Synchronous fetch buffer with push, pop, synchronous clear and occupancy.
// The caller guarantees no push when full and no pop when empty.
module decode_issue_fifo
    import decode_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   srst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;

    // Entry storage, written at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push && !srst) begin
            mem_r[tail_r] <= push_data;
        end
    end

    // Occupancy next value; clear wins over push/pop.
    always_comb begin
        count_nxt_s = count_r;
        if (srst) begin
            count_nxt_s = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1'b1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and count registers; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (srst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                tail_r <= tail_r + PTR_W'(1'b1);
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1'b1);
            end
            count_r <= count_nxt_s;
        end
    end

    assign head_data = mem_r[head_r];
    assign count     = count_r;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode front end: buffers fetched instructions, stamps each issue with a
// unique major ID and throttles issue with downstream credits.
module decode_issue_ctrl
    import decode_issue_pkg::*;
#(
    parameter int fifoDepth   = 4,
    parameter int creditCount = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic                           fetchValid_i,
    output logic                           fetchReady_o,
    input  logic [INST_WIDTH-1:0]          fetchInst_i,
    input  logic [ADDR_WIDTH-1:0]          fetchAddr_i,
    input  logic                           fetchIs64_i,
    input  logic [PID_WIDTH-1:0]           fetchPid_i,
    input  logic [TID_WIDTH-1:0]           fetchTid_i,
    input  logic                           creditReturn_i,
    output logic                           decEnable_o,
    output logic [INST_WIDTH-1:0]          decInst_o,
    output logic [ADDR_WIDTH-1:0]          decAddr_o,
    output logic                           decIs64_o,
    output logic [PID_WIDTH-1:0]           decPid_o,
    output logic [TID_WIDTH-1:0]           decTid_o,
    output logic [MAJ_ID_WIDTH-1:0]        decMajId_o,
    output logic [$clog2(fifoDepth):0]     fifoCount_o,
    output logic [$clog2(creditCount):0]   credits_o,
    output logic                           creditOverflow_o
);

    localparam int CNT_W = $clog2(fifoDepth) + 1;
    localparam int CRD_W = $clog2(creditCount) + 1;

    fetch_entry_t             fetch_entry_s;
    fetch_entry_t             head_entry_s;
    fetch_entry_t             dec_entry_r;
    logic [CNT_W-1:0]         fifo_count_s;
    logic                     fetch_ready_s;
    logic                     push_s;
    logic                     issue_s;
    logic [CRD_W-1:0]         credits_r;
    logic [CRD_W-1:0]         credits_nxt_s;
    logic                     overflow_r;
    logic                     overflow_nxt_s;
    logic [MAJ_ID_WIDTH-1:0]  maj_id_r;
    logic [MAJ_ID_WIDTH-1:0]  dec_maj_id_r;
    logic                     dec_enable_r;

    assign fetch_entry_s = '{inst: fetchInst_i, addr: fetchAddr_i, is64: fetchIs64_i,
                             pid: fetchPid_i, tid: fetchTid_i};

    // Ready depends on the registered count only, so a pop cannot free a slot in the same cycle.
    assign fetch_ready_s = (fifo_count_s < CNT_W'(fifoDepth));
    assign push_s        = fetchValid_i && fetch_ready_s && !flush_i;
    assign issue_s       = (fifo_count_s != '0) && (credits_r != '0) && !flush_i;

    decode_issue_fifo #(
        .DEPTH (fifoDepth)
    ) u_fifo (
        .clk       (clock_i),
        .rst_n     (reset_i),
        .srst      (flush_i),
        .push      (push_s),
        .push_data (fetch_entry_s),
        .pop       (issue_s),
        .head_data (head_entry_s),
        .count     (fifo_count_s)
    );

    // Credit bookkeeping; a return with the pool already full is an error, not a credit.
    always_comb begin
        credits_nxt_s  = credits_r;
        overflow_nxt_s = overflow_r;
        case ({creditReturn_i, issue_s})
            2'b10: begin
                if (credits_r == CRD_W'(creditCount)) begin
                    overflow_nxt_s = 1'b1;
                end else begin
                    credits_nxt_s = credits_r + CRD_W'(1'b1);
                end
            end
            2'b01:   credits_nxt_s = credits_r - CRD_W'(1'b1);
            default: credits_nxt_s = credits_r;
        endcase
    end

    // Credit, overflow and major ID registers; the ID survives flushes to stay unique.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            credits_r  <= CRD_W'(creditCount);
            overflow_r <= 1'b0;
            maj_id_r   <= '0;
        end else begin
            credits_r  <= credits_nxt_s;
            overflow_r <= overflow_nxt_s;
            if (issue_s) begin
                maj_id_r <= maj_id_r + MAJ_ID_WIDTH'(1'b1);
            end
        end
    end

    // Decoder-facing registers; payload holds its last value when nothing issues.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            dec_enable_r <= 1'b0;
            dec_entry_r  <= '0;
            dec_maj_id_r <= '0;
        end else begin
            dec_enable_r <= issue_s;
            if (issue_s) begin
                dec_entry_r  <= head_entry_s;
                dec_maj_id_r <= maj_id_r;
            end
        end
    end

    assign fetchReady_o     = fetch_ready_s;
    assign decEnable_o      = dec_enable_r;
    assign decInst_o        = dec_entry_r.inst;
    assign decAddr_o        = dec_entry_r.addr;
    assign decIs64_o        = dec_entry_r.is64;
    assign decPid_o         = dec_entry_r.pid;
    assign decTid_o         = dec_entry_r.tid;
    assign decMajId_o       = dec_maj_id_r;
    assign fifoCount_o      = fifo_count_s;
    assign credits_o        = credits_r;
    assign creditOverflow_o = overflow_r;

endmodule
